// File: rtl/port_responder.sv
// CPU-facing I/O port block: write-decoded digit/LED/mask registers, debounced
// push-buttons, and a multiplexed 4-digit seven-segment scanner.
module port_responder #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] SCAN_CYCLES     = 16'd1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        write_out,
    input  logic [15:0] out_port,
    input  logic [15:0] out_data,
    input  logic [2:0]  btn_raw,
    output logic [2:0]  in_data,
    output logic [3:0]  digit_sel,
    output logic [6:0]  seg,
    output logic [7:0]  led,
    output logic [7:0]  bad_port_cnt
);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [2:0]        sync1_q, sync2_q, stable_q, stable_d;
    logic [2:0][15:0]  db_cnt_q, db_cnt_d;
    logic [3:0][3:0]   digit_q, digit_d;
    logic [3:0]        mask_q, mask_d;
    logic [7:0]        led_q, led_d;
    logic [7:0]        bad_q, bad_d;
    logic [15:0]       scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        digit_sel_q, digit_sel_d;
    logic [6:0]        seg_q, seg_d;

    // Debounce: a level is accepted only after staying different for DEBOUNCE_CYCLES.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = 16'd0;
            end else if (db_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = 16'd0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 16'd1;
            end
        end
    end

    // Port write decode; unmapped ports only bump the saturating error count.
    always_comb begin
        digit_d = digit_q;
        mask_d  = mask_q;
        led_d   = led_q;
        bad_d   = bad_q;
        if (write_out) begin
            case (out_port)
                16'h0000, 16'h0001, 16'h0002, 16'h0003: digit_d[out_port[1:0]] = out_data[3:0];
                16'h0004: led_d  = out_data[7:0];
                16'h0005: mask_d = out_data[3:0];
                default: begin
                    if (bad_q != 8'hFF) begin
                        bad_d = bad_q + 8'd1;
                    end else begin
                        bad_d = bad_q;
                    end
                end
            endcase
        end else begin
            bad_d = bad_q;
        end
    end

    // Scan timer and digit index; index advances on each timer wrap.
    always_comb begin
        if (scan_q == SCAN_CYCLES - 16'd1) begin
            scan_d = 16'd0;
            idx_d  = idx_q + 2'd1;
        end else begin
            scan_d = scan_q + 16'd1;
            idx_d  = idx_q;
        end
    end

    // Display outputs are computed from the current index and registered.
    always_comb begin
        if (mask_q[idx_q]) begin
            digit_sel_d = 4'b0001 << idx_q;
        end else begin
            digit_sel_d = 4'b0000;
        end
        seg_d = hex7(digit_q[idx_q]);
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q     <= 3'b000;
            sync2_q     <= 3'b000;
            stable_q    <= 3'b000;
            db_cnt_q    <= '0;
            digit_q     <= '0;
            mask_q      <= 4'hF;
            led_q       <= 8'h00;
            bad_q       <= 8'h00;
            scan_q      <= 16'd0;
            idx_q       <= 2'd0;
            digit_sel_q <= 4'b0000;
            seg_q       <= 7'h00;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            db_cnt_q    <= db_cnt_d;
            digit_q     <= digit_d;
            mask_q      <= mask_d;
            led_q       <= led_d;
            bad_q       <= bad_d;
            scan_q      <= scan_d;
            idx_q       <= idx_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
        end
    end

    assign in_data      = stable_q;
    assign digit_sel    = digit_sel_q;
    assign seg          = seg_q;
    assign led          = led_q;
    assign bad_port_cnt = bad_q;

endmodule

// File: tb/tb_port_responder.sv
// Directed bench for port_responder with short debounce and scan periods.
module tb_port_responder;

    localparam logic [15:0] DB = 16'd4;
    localparam logic [15:0] SC = 16'd4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        write_out;
    logic [15:0] out_port;
    logic [15:0] out_data;
    logic [2:0]  btn_raw;
    logic [2:0]  in_data;
    logic [3:0]  digit_sel;
    logic [6:0]  seg;
    logic [7:0]  led;
    logic [7:0]  bad_port_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0] m_digit [4];
    logic [3:0] m_mask;
    logic [7:0] m_led;
    logic [7:0] m_bad;

    always #5 clk = ~clk;

    port_responder #(.DEBOUNCE_CYCLES(DB), .SCAN_CYCLES(SC)) dut (
        .clk(clk), .rstn(rstn), .write_out(write_out), .out_port(out_port),
        .out_data(out_data), .btn_raw(btn_raw), .in_data(in_data),
        .digit_sel(digit_sel), .seg(seg), .led(led), .bad_port_cnt(bad_port_cnt)
    );

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    // Digit index displayed after the n-th edge since reset release (scan period 4).
    function automatic int idx_at(input int n);
        return ((n - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_sel(input int n);
        int i;
        logic [3:0] oh;
        i  = idx_at(n);
        oh = 4'b0001 << i;
        return m_mask[i] ? oh : 4'b0000;
    endfunction

    function automatic logic [6:0] exp_seg(input int n);
        return hex_seg(m_digit[idx_at(n)]);
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
        m_mask = 4'hF;
        m_led  = 8'h00;
        m_bad  = 8'h00;
    endtask

    task automatic wr(input logic [15:0] p, input logic [15:0] d);
        write_out = 1'b1;
        out_port  = p;
        out_data  = d;
        tick();
        if (p < 16'd4)       m_digit[p[1:0]] = d[3:0];
        else if (p == 16'd4) m_led = d[7:0];
        else if (p == 16'd5) m_mask = d[3:0];
        else if (m_bad != 8'hFF) m_bad = m_bad + 8'd1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; write_out = 1'b0; out_port = 16'h0; out_data = 16'h0; btn_raw = 3'b000;
        #12;
        total++; if (in_data !== 3'b000) begin bad++; $display("FAIL rst_in_data got=%b exp=000", in_data); end
        total++; if (digit_sel !== 4'b0000) begin bad++; $display("FAIL rst_digit_sel got=%b exp=0000", digit_sel); end
        total++; if (seg !== 7'h00) begin bad++; $display("FAIL rst_seg got=%h exp=00", seg); end
        total++; if (led !== 8'h00) begin bad++; $display("FAIL rst_led got=%h exp=00", led); end
        total++; if (bad_port_cnt !== 8'h00) begin bad++; $display("FAIL rst_bad_cnt got=%h exp=00", bad_port_cnt); end
        @(posedge clk); #1;
        rstn = 1'b1; cyc = 0; model_reset();
        tick();
        total++; if (digit_sel !== 4'b0001) begin bad++; $display("FAIL first_sel got=%b exp=0001", digit_sel); end
        total++; if (seg !== 7'h3F) begin bad++; $display("FAIL first_seg got=%h exp=3F", seg); end
    endtask

    task automatic test_scan_digit();
        bit seen;
        seen = 1'b0;
        wr(16'h0002, 16'h000A);
        write_out = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (digit_sel !== exp_sel(cyc) || seg !== exp_seg(cyc)) begin
                bad++; $display("FAIL scan_digit got=%b/%h exp=%b/%h", digit_sel, seg, exp_sel(cyc), exp_seg(cyc));
            end
            if (!seen && idx_at(cyc) == 2) begin
                seen = 1'b1;
                total++;
                if (digit_sel !== 4'b0100 || seg !== 7'h77) begin
                    bad++; $display("FAIL digit2_A got=%b/%h exp=0100/77", digit_sel, seg);
                end
            end
        end
    endtask

    task automatic test_mask();
        logic [3:0] seq [4];
        wr(16'h0005, 16'h0005);
        write_out = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (digit_sel !== exp_sel(cyc) || seg !== exp_seg(cyc)) begin
                bad++; $display("FAIL mask_scan got=%b/%h exp=%b/%h", digit_sel, seg, exp_sel(cyc), exp_seg(cyc));
            end
            seq[idx_at(cyc)] = digit_sel;
        end
        total++;
        if (seq[0] !== 4'b0001 || seq[1] !== 4'b0000 || seq[2] !== 4'b0100 || seq[3] !== 4'b0000) begin
            bad++; $display("FAIL mask_seq got=%b %b %b %b exp=0001 0000 0100 0000", seq[0], seq[1], seq[2], seq[3]);
        end
        wr(16'h0005, 16'h000F);
        write_out = 1'b0;
    endtask

    task automatic test_led();
        wr(16'h0004, 16'hABCD);
        write_out = 1'b0;
        total++; if (led !== 8'hCD) begin bad++; $display("FAIL led_write got=%h exp=CD", led); end
        tick();
        total++; if (led !== 8'hCD) begin bad++; $display("FAIL led_hold got=%h exp=CD", led); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        seen = 1'b0;
        wr(16'h0000, 16'h0003);
        wr(16'h0000, 16'h0009);
        wr(16'h0001, 16'hFFF7);
        wr(16'h0003, 16'h000E);
        write_out = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (digit_sel !== exp_sel(cyc) || seg !== exp_seg(cyc)) begin
                bad++; $display("FAIL b2b_scan got=%b/%h exp=%b/%h", digit_sel, seg, exp_sel(cyc), exp_seg(cyc));
            end
            if (!seen && idx_at(cyc) == 0) begin
                seen = 1'b1;
                total++;
                if (seg !== 7'h6F) begin bad++; $display("FAIL b2b_digit0 got=%h exp=6F", seg); end
            end
        end
    endtask

    task automatic test_bad_port();
        for (int i = 0; i < 300; i++) begin
            wr(16'h1234, i[15:0]);
            if (i == 9) begin
                total++; if (bad_port_cnt !== 8'd10) begin bad++; $display("FAIL bad_cnt_10 got=%h exp=0A", bad_port_cnt); end
            end
            if (i == 254 || i == 255) begin
                total++; if (bad_port_cnt !== 8'hFF) begin bad++; $display("FAIL bad_cnt_sat got=%h exp=FF", bad_port_cnt); end
            end
        end
        wr(16'h0006, 16'h0001);
        write_out = 1'b0;
        total++; if (bad_port_cnt !== 8'hFF) begin bad++; $display("FAIL bad_cnt_final got=%h exp=FF", bad_port_cnt); end
        total++; if (led !== m_led) begin bad++; $display("FAIL bad_led_kept got=%h exp=%h", led, m_led); end
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (digit_sel !== exp_sel(cyc) || seg !== exp_seg(cyc)) begin
                bad++; $display("FAIL bad_scan got=%b/%h exp=%b/%h", digit_sel, seg, exp_sel(cyc), exp_seg(cyc));
            end
        end
    endtask

    task automatic test_debounce();
        logic [2:0] e;
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            e = (k >= 6) ? 3'b010 : 3'b000;
            total++; if (in_data !== e) begin bad++; $display("FAIL db_rise k=%0d got=%b exp=%b", k, in_data, e); end
        end
        btn_raw[0] = 1'b1;
        tick(); tick(); tick();
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if (in_data !== 3'b010) begin bad++; $display("FAIL db_glitch k=%0d got=%b exp=010", k, in_data); end
        end
        btn_raw[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            e = 3'b010 | ((k >= 6) ? 3'b100 : 3'b000) | ((k >= 8) ? 3'b001 : 3'b000);
            total++; if (in_data !== e) begin bad++; $display("FAIL db_indep k=%0d got=%b exp=%b", k, in_data, e); end
            if (k == 2) btn_raw[0] = 1'b1;
        end
        btn_raw[0] = 1'b0; btn_raw[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            e = (k >= 6) ? 3'b010 : 3'b111;
            total++; if (in_data !== e) begin bad++; $display("FAIL db_fall k=%0d got=%b exp=%b", k, in_data, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] e;
        tick(); tick();
        #3;
        rstn = 1'b0;
        #1;
        total++;
        if (in_data !== 3'b000 || digit_sel !== 4'b0000 || seg !== 7'h00 || led !== 8'h00 || bad_port_cnt !== 8'h00) begin
            bad++; $display("FAIL mid_rst_async got=%b/%b/%h/%h/%h exp=0", in_data, digit_sel, seg, led, bad_port_cnt);
        end
        @(posedge clk); #1;
        rstn = 1'b1; cyc = 0; model_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = (k >= 6) ? 3'b010 : 3'b000;
            total++; if (in_data !== e) begin bad++; $display("FAIL mid_rst_btn k=%0d got=%b exp=%b", k, in_data, e); end
            total++;
            if (digit_sel !== exp_sel(cyc) || seg !== exp_seg(cyc)) begin
                bad++; $display("FAIL mid_rst_scan got=%b/%h exp=%b/%h", digit_sel, seg, exp_sel(cyc), exp_seg(cyc));
            end
            if (k == 1) begin
                total++;
                if (digit_sel !== 4'b0001 || seg !== 7'h3F || led !== 8'h00 || bad_port_cnt !== 8'h00) begin
                    bad++; $display("FAIL mid_rst_first got=%b/%h/%h/%h exp=0001/3F/00/00", digit_sel, seg, led, bad_port_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_digit();
        test_mask();
        test_led();
        test_back_to_back();
        test_bad_port();
        test_debounce();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/port_responder.md
PORT_RESPONDER -- requirements
Module: PortResponder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000: cycles a synchronized button level SHALL stay stable before it is accepted; legal range 2..65535.
REQ-002 Parameter SCAN_CYCLES, default 16'd1000: cycles each display digit SHALL be held; legal range 2..65535.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 write_out  input  1  write strobe from the CPU; one write per high cycle.
REQ-006 out_port  input  16  port address qualified by write_out.
REQ-007 out_data  input  16  write data qualified by write_out.
REQ-008 btn_raw  input  3  asynchronous raw push-buttons, active-high.
REQ-009 in_data  output  3  debounced button levels returned to the CPU.
REQ-010 digit_sel  output  4  one-hot digit enable, active-high, bit i = digit i.
REQ-011 seg  output  7  segment pattern {g,f,e,d,c,b,a}, active-high.
REQ-012 led  output  8  LED register contents.
REQ-013 bad_port_cnt  output  8  count of writes to unmapped ports, saturating.

Function
REQ-014 A write SHALL be accepted on every rising edge with write_out=1; there is no back-pressure, and the new value SHALL be visible on outputs the following cycle.
REQ-015 Port map: 0x0000-0x0003 -> digit register 0-3 <= out_data[3:0]; 0x0004 -> led <= out_data[7:0]; 0x0005 -> enable mask <= out_data[3:0]; unused data bits SHALL be ignored.
REQ-016 Write to any other port: no register change; bad_port_cnt +1, holding at 8'hFF.
REQ-017 Consecutive-cycle writes, including repeated writes to one port, SHALL all take effect in order; the last write wins.
REQ-018 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-019 Per-button debounce: counter clears when the synchronized level equals the stable level; otherwise it increments, and on reaching DEBOUNCE_CYCLES-1 the stable level takes the synchronized level and the counter clears.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES SHALL never change in_data; accepted-edge latency from btn_raw to in_data SHALL be exactly DEBOUNCE_CYCLES+2 cycles.
REQ-021 Buttons SHALL debounce independently; simultaneous edges on several buttons SHALL each be accepted on their own schedule.
REQ-022 in_data SHALL be the registered stable levels.
REQ-023 Scan counter runs 0..SCAN_CYCLES-1 and wraps to 0. On each wrap the digit index (2 bits) SHALL increment, wrapping 3 -> 0.
REQ-024 digit_sel and seg SHALL be registered outputs, one cycle behind the index.
REQ-025 digit_sel = one-hot(index) when mask[index]=1, otherwise 4'b0000.
REQ-026 seg = hex decode of digit[index], regardless of mask. Required codes: 0->3F, 1->06, 2->5B, 3->4F, 4->66, 5->6D, 6->7D, 7->07, 8->7F, 9->6F, A->77, b->7C, C->39, d->5E, E->79, F->71.
REQ-027 A write to the currently displayed digit SHALL change seg within 2 cycles, without disturbing scan timing.

Reset
REQ-028 While rstn=0, immediately and asynchronously, and at release: in_data=0, digit_sel=0, seg=0, led=0, bad_port_cnt=0.
REQ-029 Also while rstn=0: digit registers=0, mask=4'hF, scan counter=0, index=0, synchronizers and stable levels=0, debounce counters=0.
REQ-030 Reset asserted mid-debounce or mid-scan SHALL discard partial counts; no accepted write survives reset.
REQ-031 First edge after release: digit_sel=4'b0001, seg=7'h3F.

Verification
REQ-032 DEBOUNCE_CYCLES=4: btn_raw[1] 0->1 held -> in_data=3'b010 exactly 6 cycles later; a 3-cycle pulse -> in_data stays 0.
REQ-033 Write port 0x0002 data 0x000A, SCAN_CYCLES=4 -> when index reaches 2: digit_sel=4'b0100, seg=7'h77.
REQ-034 Write 0x0005 data 0x0005 -> digit_sel cycles 0001, 0000, 0100, 0000; seg still follows digit values.
REQ-035 Write 0x0004 data 0xABCD -> led=8'hCD next cycle; 300 writes to 0x1234 -> bad_port_cnt=8'hFF, other registers unchanged.
REQ-036 Back-to-back writes 0x0000<-0x3, then 0x0000<-0x9 -> digit 0 shows 7'h6F.
REQ-037 rstn pulsed low mid-scan with button held -> all outputs 0 at once; after release digit_sel=0001, seg=3F, and in_data rises only after a full DEBOUNCE_CYCLES+2.
